// File: rtl/mem_write_arbiter_if.sv
// Bus bundle for mem_write_arbiter: requester command/data, memory command/data,
// and the status return path. The slave modport is the arbiter's view, the
// master modport is the view of the surrounding requesters plus memory port.
interface mem_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512
);
  localparam int KW = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]            s_cmd_valid;
  logic [NUM_REQ-1:0]            s_cmd_ready;
  logic [NUM_REQ*64-1:0]         s_cmd_address;
  logic [NUM_REQ*32-1:0]         s_cmd_length;
  logic [NUM_REQ-1:0]            s_data_valid;
  logic [NUM_REQ-1:0]            s_data_ready;
  logic [NUM_REQ-1:0]            s_data_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_data_data;
  logic [NUM_REQ*KW-1:0]         s_data_keep;

  logic                          m_cmd_valid;
  logic                          m_cmd_ready;
  logic [63:0]                   m_cmd_address;
  logic [31:0]                   m_cmd_length;
  logic                          m_data_valid;
  logic                          m_data_ready;
  logic                          m_data_last;
  logic [DATA_WIDTH-1:0]         m_data_data;
  logic [KW-1:0]                 m_data_keep;

  logic                          s_sts_valid;
  logic                          s_sts_ready;
  logic [7:0]                    s_sts_data;
  logic [NUM_REQ-1:0]            m_sts_valid;
  logic [NUM_REQ-1:0]            m_sts_ready;
  logic [7:0]                    m_sts_data;

  modport slave (
    input  s_cmd_valid, s_cmd_address, s_cmd_length,
    input  s_data_valid, s_data_last, s_data_data, s_data_keep,
    input  m_cmd_ready, m_data_ready, s_sts_valid, s_sts_data, m_sts_ready,
    output s_cmd_ready, s_data_ready,
    output m_cmd_valid, m_cmd_address, m_cmd_length,
    output m_data_valid, m_data_last, m_data_data, m_data_keep,
    output s_sts_ready, m_sts_valid, m_sts_data
  );

  modport master (
    output s_cmd_valid, s_cmd_address, s_cmd_length,
    output s_data_valid, s_data_last, s_data_data, s_data_keep,
    output m_cmd_ready, m_data_ready, s_sts_valid, s_sts_data, m_sts_ready,
    input  s_cmd_ready, s_data_ready,
    input  m_cmd_valid, m_cmd_address, m_cmd_length,
    input  m_data_valid, m_data_last, m_data_data, m_data_keep,
    input  s_sts_ready, m_sts_valid, m_sts_data
  );
endinterface

// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter sharing one memory-write command channel and one write
// data stream among NUM_REQ requesters. A granted command and its whole data
// burst pass through atomically; status words return to requesters in command
// order through a tag FIFO that runs independently of the grant FSM.
// Optional: define MEM_WR_ARB_STATS_EN to add per-requester command counters
// on output stat_cmd_count.
//
// state | meaning
// IDLE  | waiting for a command request and a free tag slot
// CMD   | granted command presented on m_cmd_*, waiting for m_cmd_ready
// DATA  | granted data stream passed through until its last beat
module mem_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int TAG_DEPTH  = 8
) (
  input logic                aclk,
  input logic                areset,
  mem_write_arbiter_if.slave bus
`ifdef MEM_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0] stat_cmd_count
`endif
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int GW = $clog2(NUM_REQ);
  localparam int AW = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] sel_idx;
  logic          sel_found;
  logic [GW:0]   cand;

  logic [GW-1:0] tag_mem [TAG_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          fifo_full, fifo_empty;
  logic          tag_push, tag_pop;
  logic [GW-1:0] head;
  logic          data_hs;

  // first requester at or after rr_ptr, searching cyclically
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(NUM_REQ)) cand = cand - (GW+1)'(NUM_REQ);
      if (bus.s_cmd_valid[cand[GW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[GW-1:0];
      end
    end
  end

  // grant FSM next state; the tag is pushed on the command handshake
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    tag_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found && !fifo_full) begin
          grant_d = sel_idx;
          state_d = CMD;
        end
      end
      CMD: begin
        if (bus.m_cmd_ready) begin
          tag_push = 1'b1;
          rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (data_hs && bus.s_data_last[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, grant and round-robin pointer registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // command and data muxing from the granted slice; fields zero while invalid
  always_comb begin
    bus.m_cmd_valid   = (state_q == CMD);
    bus.m_cmd_address = '0;
    bus.m_cmd_length  = '0;
    bus.s_cmd_ready   = '0;
    if (state_q == CMD) begin
      bus.m_cmd_address        = bus.s_cmd_address[grant_q*64 +: 64];
      bus.m_cmd_length         = bus.s_cmd_length[grant_q*32 +: 32];
      bus.s_cmd_ready[grant_q] = bus.m_cmd_ready;
    end
    bus.m_data_valid = (state_q == DATA) && bus.s_data_valid[grant_q];
    bus.m_data_data  = '0;
    bus.m_data_keep  = '0;
    bus.m_data_last  = 1'b0;
    bus.s_data_ready = '0;
    if (state_q == DATA) bus.s_data_ready[grant_q] = bus.m_data_ready;
    if (bus.m_data_valid) begin
      bus.m_data_data = bus.s_data_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
      bus.m_data_keep = bus.s_data_keep[grant_q*KW +: KW];
      bus.m_data_last = bus.s_data_last[grant_q];
    end
    data_hs = bus.m_data_valid && bus.m_data_ready;
  end

  // status routing to the requester at the head of the tag FIFO
  always_comb begin
    fifo_empty      = (wr_ptr_q == rd_ptr_q);
    fifo_full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head            = tag_mem[rd_ptr_q[AW-1:0]];
    bus.s_sts_ready = !fifo_empty && bus.m_sts_ready[head];
    bus.m_sts_valid = '0;
    bus.m_sts_data  = '0;
    if (bus.s_sts_valid && !fifo_empty) begin
      bus.m_sts_valid[head] = 1'b1;
      bus.m_sts_data        = bus.s_sts_data;
    end
    tag_pop = bus.s_sts_valid && bus.s_sts_ready;
  end

  // tag FIFO pointers; simultaneous push and pop leave the count unchanged
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (tag_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (tag_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // tag storage needs no reset: entries are only read between push and pop
  always_ff @(posedge aclk) begin
    if (tag_push) tag_mem[wr_ptr_q[AW-1:0]] <= grant_q;
  end

`ifdef MEM_WR_ARB_STATS_EN
  // per-requester accepted-command counters, wrapping at 2^32
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stat_cmd_count <= '0;
    end else if (tag_push) begin
      stat_cmd_count[grant_q*32 +: 32] <= stat_cmd_count[grant_q*32 +: 32] + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_write_arbiter.sv
// Scoreboard bench for mem_write_arbiter: requester drivers, a negedge
// monitor checking commands, data beats and status routing against queues of
// expected results, and directed scenarios for arbitration corner cases.
module tb_mem_write_arbiter;
  localparam int NR = 4;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int TD = 8;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
    int          nbeats;
  } txn_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic aclk = 1'b0;
  logic areset;
`ifdef MEM_WR_ARB_STATS_EN
  logic [NR*32-1:0] stat_cmd_count;
`endif

  mem_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  mem_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
`ifdef MEM_WR_ARB_STATS_EN
    ,
    .stat_cmd_count (stat_cmd_count)
`endif
  );

  always #5 aclk = ~aclk;

  int      n_checks = 0;
  int      n_fail   = 0;
  txn_t    txq [NR][$];
  txn_t    cur [NR];
  int      phase [NR];
  int      beat [NR];
  int      exp_grant [$];
  int      exp_route [$];
  beat_t   exp_beat [$];
  logic [NR-1:0] cmd_fire_q  = '0;
  logic [NR-1:0] data_fire_q = '0;
  bit      burst_open = 0;
  bit      toggle_rdy = 0;
  int      cmd_count  = 0;
  int      beats_seen = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int req, input logic [63:0] addr, input int b);
    logic [DW-1:0] v;
    v = {8'(req), addr[23:0], 32'(b)};
    return v;
  endfunction

  function automatic logic [KW-1:0] beat_keep(input bit last);
    return last ? 8'h0F : 8'hFF;
  endfunction

  function automatic bit bench_idle();
    for (int i = 0; i < NR; i++)
      if (txq[i].size() != 0 || phase[i] != 0) return 1'b0;
    return (exp_beat.size() == 0) && (exp_grant.size() == 0) && !burst_open;
  endfunction

  task automatic queue_txn(input int req, input logic [63:0] addr, input logic [31:0] len, input int nb);
    txn_t t;
    t.addr = addr; t.len = len; t.nbeats = nb;
    txq[req].push_back(t);
  endtask

  task automatic present_beat(input int i);
    bit last;
    last = (beat[i] == cur[i].nbeats - 1);
    bus.s_data_valid[i]            = 1'b1;
    bus.s_data_data[i*DW +: DW]    = beat_data(i, cur[i].addr, beat[i]);
    bus.s_data_keep[i*KW +: KW]    = beat_keep(last);
    bus.s_data_last[i]             = last;
  endtask

  // requester drivers: command first, then the data burst, then the next txn
  initial begin
    for (int i = 0; i < NR; i++) begin phase[i] = 0; beat[i] = 0; end
    forever begin
      @(posedge aclk); #1;
      if (areset) begin
        for (int i = 0; i < NR; i++) begin phase[i] = 0; beat[i] = 0; end
        bus.s_cmd_valid  = '0;
        bus.s_data_valid = '0;
        bus.s_data_last  = '0;
      end else begin
        for (int i = 0; i < NR; i++) begin
          if (phase[i] == 1 && cmd_fire_q[i]) begin
            bus.s_cmd_valid[i] = 1'b0;
            phase[i] = 2;
            beat[i]  = 0;
            present_beat(i);
          end else if (phase[i] == 2 && data_fire_q[i]) begin
            beat[i]++;
            if (beat[i] == cur[i].nbeats) begin
              bus.s_data_valid[i] = 1'b0;
              bus.s_data_last[i]  = 1'b0;
              phase[i] = 0;
            end else begin
              present_beat(i);
            end
          end
          if (phase[i] == 0 && txq[i].size() > 0) begin
            cur[i] = txq[i].pop_front();
            bus.s_cmd_valid[i]         = 1'b1;
            bus.s_cmd_address[i*64 +: 64] = cur[i].addr;
            bus.s_cmd_length[i*32 +: 32]  = cur[i].len;
            phase[i] = 1;
          end
        end
        if (toggle_rdy) bus.m_data_ready = ~bus.m_data_ready;
      end
    end
  end

  // monitor: every handshake is checked against the expected queues
  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        cmd_fire_q  = '0;
        data_fire_q = '0;
      end else begin
        cmd_fire_q  = bus.s_cmd_valid & bus.s_cmd_ready;
        data_fire_q = bus.s_data_valid & bus.s_data_ready;
        if (bus.m_cmd_valid && bus.m_cmd_ready) begin
          int g;
          g = -1;
          for (int i = 0; i < NR; i++) if (bus.s_cmd_ready[i]) g = i;
          if (exp_grant.size() == 0) check_eq("grant_extra", 64'(g), 64'hEE);
          else check_eq("grant", 64'(g), 64'(exp_grant.pop_front()));
          check_eq("burst_atomic", 64'(burst_open), 64'd0);
          if (g >= 0) begin
            check_eq("cmd_addr", bus.m_cmd_address, cur[g].addr);
            check_eq("cmd_len", 64'(bus.m_cmd_length), 64'(cur[g].len));
            for (int b = 0; b < cur[g].nbeats; b++) begin
              beat_t e;
              e.last = (b == cur[g].nbeats - 1);
              e.data = beat_data(g, cur[g].addr, b);
              e.keep = beat_keep(e.last);
              exp_beat.push_back(e);
            end
            exp_route.push_back(g);
          end
          burst_open = 1;
          cmd_count++;
        end
        if (bus.m_data_valid && bus.m_data_ready) begin
          beats_seen++;
          if (exp_beat.size() == 0) begin
            check_eq("beat_avail", 64'(exp_beat.size()), 64'd1);
          end else begin
            beat_t e;
            e = exp_beat.pop_front();
            check_eq("beat_data", bus.m_data_data, e.data);
            check_eq("beat_keep", 64'(bus.m_data_keep), 64'(e.keep));
            check_eq("beat_last", 64'(bus.m_data_last), 64'(e.last));
            if (e.last) burst_open = 0;
          end
        end
        if (bus.s_sts_valid && bus.s_sts_ready) begin
          if (exp_route.size() == 0) begin
            check_eq("sts_route_avail", 64'(exp_route.size()), 64'd1);
          end else begin
            int r;
            r = exp_route.pop_front();
            check_eq("sts_route", 64'(bus.m_sts_valid), 64'(1) << r);
            check_eq("sts_data", 64'(bus.m_sts_data), 64'(bus.s_sts_data));
          end
        end
      end
    end
  end

  task automatic do_reset(input bit chk);
    areset = 1'b1;
    toggle_rdy = 0;
    bus.m_cmd_ready  = 1'b1;
    bus.m_data_ready = 1'b1;
    bus.m_sts_ready  = '1;
    bus.s_sts_valid  = 1'b0;
    #1;
    if (chk) begin
      check_eq("rst_m_cmd_valid", 64'(bus.m_cmd_valid), 64'd0);
      check_eq("rst_m_cmd_addr", bus.m_cmd_address, 64'd0);
      check_eq("rst_s_cmd_ready", 64'(bus.s_cmd_ready), 64'd0);
      check_eq("rst_m_data_valid", 64'(bus.m_data_valid), 64'd0);
      check_eq("rst_s_data_ready", 64'(bus.s_data_ready), 64'd0);
      check_eq("rst_s_sts_ready", 64'(bus.s_sts_ready), 64'd0);
      check_eq("rst_m_sts_valid", 64'(bus.m_sts_valid), 64'd0);
    end
    for (int i = 0; i < NR; i++) txq[i].delete();
    exp_grant.delete();
    exp_route.delete();
    exp_beat.delete();
    burst_open = 0;
    cmd_count  = 0;
    beats_seen = 0;
    repeat (2) @(posedge aclk);
    #3;
    areset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge aclk); #3;
      done = bench_idle();
    end
    check_eq("idle_reached", 64'(done), 64'd1);
  endtask

  task automatic send_sts(input logic [7:0] d);
    bit hs;
    hs = 0;
    bus.s_sts_valid = 1'b1;
    bus.s_sts_data  = d;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge aclk);
      hs = bus.s_sts_ready;
    end
    @(posedge aclk); #3;
    bus.s_sts_valid = 1'b0;
    check_eq("sts_handshake", 64'(hs), 64'd1);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b0;
    bus.s_cmd_valid = '0; bus.s_cmd_address = '0; bus.s_cmd_length = '0;
    bus.s_data_valid = '0; bus.s_data_last = '0; bus.s_data_data = '0; bus.s_data_keep = '0;
    bus.m_cmd_ready = 1'b1; bus.m_data_ready = 1'b1;
    bus.s_sts_valid = 1'b0; bus.s_sts_data = '0; bus.m_sts_ready = '1;
    #2;
    do_reset(1);

    // single request from requester 1, one-cycle arbitration latency
    queue_txn(1, 64'h1000, 32'd128, 2);
    exp_grant.push_back(1);
    @(posedge aclk); #3;
    @(negedge aclk);
    check_eq("latency_n", 64'(bus.m_cmd_valid), 64'd0);
    @(negedge aclk);
    check_eq("latency_n1", 64'(bus.m_cmd_valid), 64'd1);
    wait_idle(50);
    send_sts(8'h00);

    // fairness with all requesters valid, including a zero-length command
    do_reset(0);
    queue_txn(0, 64'h100, 32'd64, 1);
    queue_txn(0, 64'h500, 32'd64, 1);
    queue_txn(1, 64'h200, 32'd128, 2);
    queue_txn(2, 64'h300, 32'd0, 1);
    queue_txn(3, 64'h400, 32'd32, 1);
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
    exp_grant.push_back(3); exp_grant.push_back(0);
    wait_idle(200);
`ifdef MEM_WR_ARB_STATS_EN
    check_eq("stat_req0", 64'(stat_cmd_count[31:0]), 64'd2);
`endif

    // burst atomicity with a stuttering memory data port
    do_reset(0);
    toggle_rdy = 1;
    queue_txn(0, 64'hA000, 32'd256, 4);
    exp_grant.push_back(0); exp_grant.push_back(2);
    repeat (3) @(posedge aclk);
    #3;
    queue_txn(2, 64'hB000, 32'd64, 1);
    wait_idle(200);
    toggle_rdy = 0;
    bus.m_data_ready = 1'b1;

    // tag FIFO full blocks the ninth grant until one status returns
    do_reset(0);
    for (int k = 0; k < TD + 1; k++) begin
      queue_txn(1, 64'(32'h2000 + k * 32'h40), 32'd64, 1);
      exp_grant.push_back(1);
    end
    begin
      bit done;
      done = 0;
      for (int c = 0; c < 300 && !done; c++) begin
        @(posedge aclk); #3;
        done = (cmd_count == TD) && !burst_open;
      end
      check_eq("fifo_fill", 64'(done), 64'd1);
    end
    repeat (5) @(posedge aclk);
    #3;
    check_eq("fifo_full_count", 64'(cmd_count), 64'(TD));
    check_eq("fifo_full_block", 64'(bus.m_cmd_valid), 64'd0);
    bus.s_sts_valid = 1'b1;
    bus.s_sts_data  = 8'h11;
    @(negedge aclk);
    check_eq("fifo_full_sts_ready", 64'(bus.s_sts_ready), 64'd1);
    @(posedge aclk); #3;
    bus.s_sts_valid = 1'b0;
    @(negedge aclk);
    check_eq("grant_after_pop_wait", 64'(bus.m_cmd_valid), 64'd0);
    @(negedge aclk);
    check_eq("grant_after_pop", 64'(bus.m_cmd_valid), 64'd1);
    wait_idle(50);

    // status routing in command order with a stalled requester 0
    do_reset(0);
    bus.m_sts_ready = 4'b1110;
    queue_txn(3, 64'h3000, 32'd64, 1); exp_grant.push_back(3);
    wait_idle(50);
    queue_txn(0, 64'h3100, 32'd64, 2); exp_grant.push_back(0);
    wait_idle(50);
    queue_txn(3, 64'h3200, 32'd64, 1); exp_grant.push_back(3);
    wait_idle(50);
    send_sts(8'h01);
    bus.s_sts_valid = 1'b1;
    bus.s_sts_data  = 8'h02;
    @(negedge aclk);
    check_eq("sts_stall_ready", 64'(bus.s_sts_ready), 64'd0);
    check_eq("sts_stall_valid", 64'(bus.m_sts_valid), 64'b0001);
    @(posedge aclk); #3;
    bus.m_sts_ready = '1;
    @(negedge aclk);
    check_eq("sts_unstall", 64'(bus.s_sts_ready), 64'd1);
    @(posedge aclk); #3;
    bus.s_sts_valid = 1'b0;
    send_sts(8'h03);

    // reset in the middle of a burst
    do_reset(0);
    queue_txn(0, 64'h4000, 32'd192, 3);
    exp_grant.push_back(0);
    begin
      bit seen;
      seen = 0;
      for (int c = 0; c < 50 && !seen; c++) begin
        @(posedge aclk); #3;
        seen = (beats_seen >= 1);
      end
      check_eq("midburst_beat1", 64'(seen), 64'd1);
    end
    do_reset(1);
    bus.s_sts_valid = 1'b1;
    bus.s_sts_data  = 8'h55;
    @(negedge aclk);
    check_eq("post_rst_fifo_empty", 64'(bus.s_sts_ready), 64'd0);
    check_eq("post_rst_no_sts", 64'(bus.m_sts_valid), 64'd0);
    @(posedge aclk); #3;
    bus.s_sts_valid = 1'b0;
    queue_txn(2, 64'h5200, 32'd64, 1);
    queue_txn(0, 64'h5000, 32'd64, 1);
    exp_grant.push_back(0); exp_grant.push_back(2);
    wait_idle(100);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
